// File: rtl/trap_pkg_rv32.sv
// trap_pkg_rv32: shared trap cause codes, PC select codes and controller state encoding
package trap_pkg_rv32;
  localparam logic [3:0] CAUSE_IMIS = 4'd0;
  localparam logic [3:0] CAUSE_ILL  = 4'd2;
  localparam logic [3:0] CAUSE_MSI  = 4'd3;
  localparam logic [3:0] CAUSE_LMIS = 4'd4;
  localparam logic [3:0] CAUSE_SMIS = 4'd6;
  localparam logic [3:0] CAUSE_MTI  = 4'd7;
  localparam logic [3:0] CAUSE_MEI  = 4'd11;
  localparam logic [1:0] PC_SRC_NORM = 2'b00;
  localparam logic [1:0] PC_SRC_TRAP = 2'b01;
  localparam logic [1:0] PC_SRC_MRET = 2'b10;
  typedef enum logic [1:0] {
    S_RESET       = 2'd0,
    S_OPERATING   = 2'd1,
    S_TRAP_TAKEN  = 2'd2,
    S_TRAP_RETURN = 2'd3
  } trap_state_t;
endpackage

// File: rtl/trap_prio_enc_rv32.sv
// trap_prio_enc_rv32: picks the highest-priority pending exception or enabled interrupt
module trap_prio_enc_rv32
  import trap_pkg_rv32::*;
(
  input  logic       imis,
  input  logic       ill,
  input  logic       lmis,
  input  logic       smis,
  input  logic       mie,
  input  logic       meie,
  input  logic       mtie,
  input  logic       msie,
  input  logic       e_irq,
  input  logic       t_irq,
  input  logic       s_irq,
  output logic       valid,
  output logic [3:0] cause,
  output logic       irq
);
  logic exc, ei, ti, si;
  // exceptions ignore mstatus.MIE; interrupts need global and per-source enables
  always_comb begin
    exc   = imis | ill | lmis | smis;
    ei    = mie & meie & e_irq;
    si    = mie & msie & s_irq;
    ti    = mie & mtie & t_irq;
    valid = exc | ei | si | ti;
    irq   = !exc && (ei | si | ti);
    cause = imis ? CAUSE_IMIS : ill ? CAUSE_ILL : lmis ? CAUSE_LMIS : smis ? CAUSE_SMIS :
            ei ? CAUSE_MEI : si ? CAUSE_MSI : ti ? CAUSE_MTI : 4'd0;
  end
endmodule

// File: rtl/trap_ctrl_rv32.sv
// trap_ctrl_rv32: machine-mode trap/MRET sequencing and CSR/PC control strobes
module trap_ctrl_rv32
  import trap_pkg_rv32::*;
#(
  parameter int VECTORED = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        mret_in,
  input  logic        misaligned_instr_in,
  input  logic        illegal_instr_in,
  input  logic        misaligned_load_in,
  input  logic        misaligned_store_in,
  input  logic        mie_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        e_irq_in,
  input  logic        t_irq_in,
  input  logic        s_irq_in,
  output logic        set_cause_out,
  output logic [3:0]  cause_out,
  output logic        i_or_e_out,
  output logic        set_epc_out,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic [1:0]  pc_src_out,
  output logic [31:0] vec_offset_out,
  output logic        flush_out
);
  trap_state_t state;
  logic [3:0]  lat_cause;
  logic        lat_irq;
  logic        enc_valid, enc_irq;
  logic [3:0]  enc_cause;
  logic        op, trap, ret, taken, rtn;

  trap_prio_enc_rv32 u_enc (
    .imis  (misaligned_instr_in),
    .ill   (illegal_instr_in),
    .lmis  (misaligned_load_in),
    .smis  (misaligned_store_in),
    .mie   (mie_in),
    .meie  (meie_in),
    .mtie  (mtie_in),
    .msie  (msie_in),
    .e_irq (e_irq_in),
    .t_irq (t_irq_in),
    .s_irq (s_irq_in),
    .valid (enc_valid),
    .cause (enc_cause),
    .irq   (enc_irq)
  );

  // output decode; an asserted reset forces every output to its idle value
  always_comb begin
    op             = rst_in && state == S_OPERATING && !stall_in;
    trap           = op && enc_valid;
    ret            = op && !enc_valid && mret_in;
    taken          = rst_in && state == S_TRAP_TAKEN;
    rtn            = rst_in && state == S_TRAP_RETURN;
    set_cause_out  = trap;
    set_epc_out    = trap;
    cause_out      = trap ? enc_cause : 4'd0;
    i_or_e_out     = trap && enc_irq;
    flush_out      = trap | ret | taken | rtn;
    mie_clear_out  = taken;
    mie_set_out    = rtn;
    pc_src_out     = taken ? PC_SRC_TRAP : rtn ? PC_SRC_MRET : PC_SRC_NORM;
    vec_offset_out = (VECTORED != 0 && taken && lat_irq) ? {26'b0, lat_cause, 2'b00} : 32'd0;
  end

  // FSM state and latched cause for the vector offset in the following cycle
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= S_RESET;
      lat_cause <= 4'd0;
      lat_irq   <= 1'b0;
    end else begin
      case (state)
        S_RESET:       state <= S_OPERATING;
        S_OPERATING:   begin
          if (trap) begin
            state     <= S_TRAP_TAKEN;
            lat_cause <= enc_cause;
            lat_irq   <= enc_irq;
          end else if (ret) begin
            state <= S_TRAP_RETURN;
          end
        end
        S_TRAP_TAKEN:  state <= S_OPERATING;
        S_TRAP_RETURN: state <= S_OPERATING;
        default:       state <= S_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl_rv32.sv
// tb_trap_ctrl_rv32: directed vectors for the trap controller with vectored mode enabled
module tb_trap_ctrl_rv32;
  logic        clk_in = 1'b0;
  logic        rst_in, stall_in, mret_in;
  logic        misaligned_instr_in, illegal_instr_in, misaligned_load_in, misaligned_store_in;
  logic        mie_in, meie_in, mtie_in, msie_in, e_irq_in, t_irq_in, s_irq_in;
  logic        set_cause_out, i_or_e_out, set_epc_out, mie_clear_out, mie_set_out, flush_out;
  logic [3:0]  cause_out;
  logic [1:0]  pc_src_out;
  logic [31:0] vec_offset_out;
  int total = 0;
  int bad = 0;

  trap_ctrl_rv32 #(.VECTORED(1)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .stall_in            (stall_in),
    .mret_in             (mret_in),
    .misaligned_instr_in (misaligned_instr_in),
    .illegal_instr_in    (illegal_instr_in),
    .misaligned_load_in  (misaligned_load_in),
    .misaligned_store_in (misaligned_store_in),
    .mie_in              (mie_in),
    .meie_in             (meie_in),
    .mtie_in             (mtie_in),
    .msie_in             (msie_in),
    .e_irq_in            (e_irq_in),
    .t_irq_in            (t_irq_in),
    .s_irq_in            (s_irq_in),
    .set_cause_out       (set_cause_out),
    .cause_out           (cause_out),
    .i_or_e_out          (i_or_e_out),
    .set_epc_out         (set_epc_out),
    .mie_clear_out       (mie_clear_out),
    .mie_set_out         (mie_set_out),
    .pc_src_out          (pc_src_out),
    .vec_offset_out      (vec_offset_out),
    .flush_out           (flush_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr;
    stall_in = 0; mret_in = 0;
    misaligned_instr_in = 0; illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0;
    mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; e_irq_in = 0; t_irq_in = 0; s_irq_in = 0;
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input string tag);
    chk({tag, "_setc"}, {31'd0, set_cause_out}, 0);
    chk({tag, "_flush"}, {31'd0, flush_out}, 0);
    chk({tag, "_pcsrc"}, {30'd0, pc_src_out}, 0);
  endtask

  initial begin
    clr();
    rst_in = 0;
    illegal_instr_in = 1;
    #1;
    chk("rst0_setc", {31'd0, set_cause_out}, 0);
    chk("rst0_pcsrc", {30'd0, pc_src_out}, 0);
    tick();
    chk("rst1_setc", {31'd0, set_cause_out}, 0);
    tick();
    chk("rst2_setc", {31'd0, set_cause_out}, 0);
    chk("rst2_pcsrc", {30'd0, pc_src_out}, 0);
    rst_in = 1;
    #1;
    chk("sreset_setc", {31'd0, set_cause_out}, 0);
    tick();
    chk("ill_setc", {31'd0, set_cause_out}, 1);
    chk("ill_cause", {28'd0, cause_out}, 2);
    chk("ill_ie", {31'd0, i_or_e_out}, 0);
    chk("ill_epc", {31'd0, set_epc_out}, 1);
    chk("ill_flush", {31'd0, flush_out}, 1);
    tick(); clr(); #1;
    chk("ill_tt_pcsrc", {30'd0, pc_src_out}, 1);
    chk("ill_tt_mieclr", {31'd0, mie_clear_out}, 1);
    chk("ill_tt_flush", {31'd0, flush_out}, 1);
    chk("ill_tt_vec", vec_offset_out, 0);
    chk("ill_tt_setc", {31'd0, set_cause_out}, 0);
    tick();
    idle("ill_after");
    mie_in = 1; meie_in = 1; mtie_in = 1; e_irq_in = 1; t_irq_in = 1; #1;
    chk("mei_cause", {28'd0, cause_out}, 11);
    chk("mei_ie", {31'd0, i_or_e_out}, 1);
    chk("mei_setc", {31'd0, set_cause_out}, 1);
    tick();
    mie_in = 0; #1;
    chk("mei_tt_vec", vec_offset_out, 32'h2C);
    chk("mei_tt_pcsrc", {30'd0, pc_src_out}, 1);
    tick();
    chk("mei_masked_setc", {31'd0, set_cause_out}, 0);
    chk("mei_after_vec", vec_offset_out, 0);
    clr(); mie_in = 1; msie_in = 1; mtie_in = 1; s_irq_in = 1; t_irq_in = 1; #1;
    chk("msi_cause", {28'd0, cause_out}, 3);
    tick(); clr(); #1;
    chk("msi_tt_vec", vec_offset_out, 32'hC);
    tick();
    t_irq_in = 1; mtie_in = 1; #1;
    chk("mti_off_setc", {31'd0, set_cause_out}, 0);
    chk("mti_off_flush", {31'd0, flush_out}, 0);
    mie_in = 1; #1;
    chk("mti_cause", {28'd0, cause_out}, 7);
    tick(); clr(); #1;
    chk("mti_tt_vec", vec_offset_out, 32'h1C);
    misaligned_instr_in = 1; misaligned_load_in = 1; #1;
    chk("tt_ignores_in", {31'd0, set_cause_out}, 0);
    tick();
    chk("nested_imis_cause", {28'd0, cause_out}, 0);
    chk("nested_imis_setc", {31'd0, set_cause_out}, 1);
    tick(); clr(); tick();
    misaligned_load_in = 1; misaligned_store_in = 1; e_irq_in = 1; meie_in = 1; mie_in = 1; #1;
    chk("lmis_cause", {28'd0, cause_out}, 4);
    chk("lmis_ie", {31'd0, i_or_e_out}, 0);
    tick(); clr(); #1;
    chk("lmis_tt_vec", vec_offset_out, 0);
    tick();
    illegal_instr_in = 1; mret_in = 1; #1;
    chk("illret_cause", {28'd0, cause_out}, 2);
    chk("illret_setc", {31'd0, set_cause_out}, 1);
    tick(); clr(); #1;
    chk("illret_pcsrc", {30'd0, pc_src_out}, 1);
    chk("illret_mieset", {31'd0, mie_set_out}, 0);
    tick();
    mret_in = 1; #1;
    chk("mret_flush", {31'd0, flush_out}, 1);
    chk("mret_setc", {31'd0, set_cause_out}, 0);
    chk("mret_epc", {31'd0, set_epc_out}, 0);
    tick(); clr(); #1;
    chk("mret_tr_pcsrc", {30'd0, pc_src_out}, 2);
    chk("mret_tr_mieset", {31'd0, mie_set_out}, 1);
    chk("mret_tr_flush", {31'd0, flush_out}, 1);
    tick();
    idle("mret_after");
    chk("mret_after_mieset", {31'd0, mie_set_out}, 0);
    stall_in = 1; misaligned_store_in = 1; #1;
    idle("stall0");
    chk("stall0_epc", {31'd0, set_epc_out}, 0);
    tick();
    idle("stall1");
    stall_in = 0; #1;
    chk("smis_cause", {28'd0, cause_out}, 6);
    chk("smis_setc", {31'd0, set_cause_out}, 1);
    tick(); clr(); #1;
    chk("smis_tt_pcsrc", {30'd0, pc_src_out}, 1);
    rst_in = 0;
    illegal_instr_in = 1;
    tick();
    idle("rst_tt");
    chk("rst_tt_mieclr", {31'd0, mie_clear_out}, 0);
    rst_in = 1; #1;
    idle("rst_tt_sreset");
    tick();
    chk("rst_tt_op_cause", {28'd0, cause_out}, 2);
    chk("rst_tt_op_setc", {31'd0, set_cause_out}, 1);
    tick(); clr(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
